serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial addition controller that reuses one external `full_adder` instance for a WIDTH-bit add, one bit per clock, LSB first.
- Loads both operands and the carry-in on a start request, then drives the full adder's a/b/cin pins from internal shift registers.
- Collects the sum bit and carry from the full adder each cycle, then presents the WIDTH-bit sum and the carry-out with a one-cycle done pulse.
- It is the sequencing layer above the 1-bit adder datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an add; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  initial carry-in; captured on the accepting edge.
- fa_a  output  1  to `full_adder` input a.
- fa_b  output  1  to `full_adder` input b.
- fa_cin  output  1  to `full_adder` input cin.
- fa_s  input  1  from `full_adder` output s.
- fa_cout  input  1  from `full_adder` output cout.
- busy  output  1  high while an add is in progress or completing (state != IDLE).
- done  output  1  one-cycle pulse when sum/cout are valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  final carry-out; held with sum.

Behaviour:
- Reset (async, any state): state=IDLE; shift registers, carry flop and bit counter cleared; busy=0, done=0, sum=0, cout=0; fa_a=fa_b=fa_cin=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - fa_* driven 0.
  - On an edge with start=1: opA<=a, opB<=b, carry<=cin, cnt<=0, state<=RUN.
  - sum and cout keep their previous values until the first RUN edge overwrites sum.
- RUN:
  - Combinationally, fa_a=opA[0], fa_b=opB[0], fa_cin=carry.
  - Each edge: opA/opB shift right by 1; sum shifts right with fa_s inserted at MSB; carry<=fa_cout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: cout<=fa_cout, state<=DONE.
  - Exactly WIDTH RUN edges occur; after the last one, sum[i] holds bit i of the result.
- DONE:
  - done=1 for exactly one cycle; fa_* driven 0.
  - Next edge: state<=IDLE, done<=0.
- Latency:
  - start accepted at edge E0; done is high in the cycle after edge E0+WIDTH.
  - The next start is accepted no earlier than edge E0+WIDTH+2.
  - Throughput is one add per WIDTH+2 cycles.
- busy is 1 in RUN and DONE and 0 in IDLE; it is a registered function of state, with no combinational path from start.
- start while busy (RUN or DONE): ignored, with no effect on operands or result; it is not queued.
- a/b/cin changing while busy: no effect, since they are captured only at accept.
- Reset mid-RUN: the operation is aborted immediately with no done pulse, and all outputs take their reset values.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- The full adder is purely combinational; the controller assumes fa_s/fa_cout settle within the same cycle.
- Counter width: $clog2(WIDTH), minimum 1 bit.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, pulse start -> done pulse exactly 9 cycles after the accept edge; sum=0x96, cout=0; busy high for 9 cycles.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (carry ripples all 8 bits). Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start held high continuously with a=0x01, b=0x02 -> adds accepted every 10 cycles, each giving sum=0x03. Change a to 0x80 mid-RUN -> the current result is still 0x03.
- Assert rst for 1 cycle at cnt=4 during an add of 0xAA+0x55 -> busy=0, sum=0, cout=0 immediately, no done pulse. Then a new start with 0x10+0x20 -> sum=0x30.
- WIDTH=1, all 8 combinations of a/b/cin (full-adder truth table: 000,001,...,111) -> {cout,sum} matches 00,01,01,10,01,10,10,11. Each done arrives 2 cycles after its accept edge.
- Hold fa_* and done checks across all runs: fa_a/fa_b/fa_cin=0 in IDLE/DONE, and done never high for more than 1 consecutive cycle.

Source files
------------

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial addition controller. Sequences one external
//                combinational full adder over a WIDTH-bit add, LSB first,
//                one bit per clock, then presents sum/cout with a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter needs at least one bit even when WIDTH == 1.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_shift;

  assign w_last      = (r_cnt == LAST_CNT);
  // New sum bit enters at the MSB; after WIDTH shifts bit i sits at sum[i].
  assign w_sum_shift = WIDTH'({fa_s, r_sum} >> 1);

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and full-adder pin drive (pins are quiet outside RUN).
  always_comb begin
    w_state_nxt = r_state;
    fa_a        = 1'b0;
    fa_b        = 1'b0;
    fa_cin      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        fa_a   = r_op_a[0];
        fa_b   = r_op_b[0];
        fa_cin = r_carry;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one shift per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_sum   <= w_sum_shift;
          r_carry <= fa_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cout <= fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1)
//                with behavioural full adders and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH = 8 instance signals
  logic       start8, cin8, fa_a8, fa_b8, fa_cin8, fa_s8, fa_cout8;
  logic       busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  // WIDTH = 1 instance signals
  logic       start1, cin1, fa_a1, fa_b1, fa_cin1, fa_s1, fa_cout1;
  logic       busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  // Behavioural full adders
  assign fa_s8    = fa_a8 ^ fa_b8 ^ fa_cin8;
  assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
  assign fa_s1    = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_s(fa_s8), .fa_cout(fa_cout8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_cout(fa_cout1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected {cout,sum} pushed at the accepting edge.
  typedef struct {
    logic [8:0] res;
    int         acc;
  } sb_t;
  sb_t q8[$];
  sb_t q1[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst && start8 && !busy8)
      q8.push_back('{res: {1'b0, a8} + {1'b0, b8} + {8'b0, cin8}, acc: cyc});
    if (!rst && start1 && !busy1)
      q1.push_back('{res: {1'b0, a1} + {1'b0, b1} + {1'b0, cin1}, acc: cyc});
  end

  // WIDTH = 8 monitor: result, latency, done width, busy length, quiet fa pins.
  logic pdone8 = 1'b0, pbusy8 = 1'b0;
  int   blen8  = 0;
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      blen8 = 0;
      q8.delete();
    end else begin
      if (done8) begin
        chk("done8_expected", 32'(q8.size() > 0), 1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          chk("sum8", 32'(sum8), 32'(e.res[7:0]));
          chk("cout8", 32'(cout8), 32'(e.res[8]));
          chk("latency8", 32'(cyc - e.acc), 8);
        end
        chk("done8_single", 32'(pdone8), 0);
      end
      if (!busy8 || done8) chk("fa8_quiet", {29'b0, fa_a8, fa_b8, fa_cin8}, 0);
      if (busy8) blen8++;
      else if (pbusy8) begin
        chk("busy8_len", 32'(blen8), 9);
        blen8 = 0;
      end
    end
    pdone8 = done8;
    pbusy8 = busy8;
  end

  // WIDTH = 1 monitor
  logic pdone1 = 1'b0, pbusy1 = 1'b0;
  int   blen1  = 0;
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      blen1 = 0;
      q1.delete();
    end else begin
      if (done1) begin
        chk("done1_expected", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("sum1", 32'(sum1), 32'(e.res[0]));
          chk("cout1", 32'(cout1), 32'(e.res[1]));
          chk("latency1", 32'(cyc - e.acc), 1);
        end
        chk("done1_single", 32'(pdone1), 0);
      end
      if (!busy1 || done1) chk("fa1_quiet", {29'b0, fa_a1, fa_b1, fa_cin1}, 0);
      if (busy1) blen1++;
      else if (pbusy1) begin
        chk("busy1_len", 32'(blen1), 2);
        blen1 = 0;
      end
    end
    pdone1 = done1;
    pbusy1 = busy1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(input int lim);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done8 && n < lim);
    chk("done8_seen", 32'(done8), 1);
  endtask

  task automatic wait_done1(input int lim);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done1 && n < lim);
    chk("done1_seen", 32'(done1), 1);
  endtask

  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(40);
    tick();
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t       vecs[8];
  logic [1:0] exp1[8];
  int         d1, d2;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    exp1    = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_sum8", 32'(sum8), 0);
    chk("rst_cout8", 32'(cout8), 0);
    chk("rst_fa8", {29'b0, fa_a8, fa_b8, fa_cin8}, 0);
    chk("rst_busy1", 32'(busy1), 0);
    #1 rst = 1'b0;
    tick();

    // Table-driven WIDTH = 8 vectors
    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin);
      chk("tbl_sum8", 32'(sum8), 32'(vecs[i].sum));
      chk("tbl_cout8", 32'(cout8), 32'(vecs[i].cout));
      chk("tbl_idle8", 32'(busy8), 0);
    end

    // Start held high; operand change mid-RUN affects only the next add
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    tick();
    repeat (3) tick();
    a8 = 8'h80;
    wait_done8(40);
    chk("cont_sum_first", 32'(sum8), 32'h03);
    d1 = cyc;
    wait_done8(40);
    d2 = cyc;
    start8 = 1'b0;
    chk("cont_sum_second", 32'(sum8), 32'h82);
    chk("cont_period", 32'(d2 - d1), 10);
    tick();
    tick();

    // Asynchronous reset mid-RUN at cnt == 4
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_done", 32'(done8), 0);
    chk("abort_sum", 32'(sum8), 0);
    chk("abort_cout", 32'(cout8), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (12) tick();
    chk("abort_no_restart", 32'(busy8), 0);
    run8(8'h10, 8'h20, 1'b0);
    chk("post_abort_sum", 32'(sum8), 32'h30);

    // WIDTH = 1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_done1(10);
      chk("tt1", {30'b0, cout1, sum1}, 32'(exp1[i]));
      tick();
    end

    repeat (3) tick();
    chk("q8_drained", 32'(q8.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
